// File: rtl/d_branch_predict_cmp.sv
// d_branch_predict_cmp
//   D-stage branch resolver with a 2-bit saturating-counter branch history
//   table (BHT). F reads a direction prediction combinationally, and D
//   resolves the branch in the same cycle. A real branch trains its counter
//   at the rising clock edge. A mispredict is flagged so that fetch can be
//   redirected.
//
// Optional feature: define BP_STATS_EN to add the saturating statistics
//   outputs stat_branches / stat_mispred.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset; every counter returns to 01
//   f_pc          F-stage PC used for the lookup
//   f_pred_taken  prediction for f_pc (counter MSB, combinational)
//   d_valid       D holds a live, non-stalled branch
//   d_pc          PC of the D-stage branch (selects the entry to update)
//   d_b_type      0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 rsvd
//   d_in1, d_in2  forwarded rs / rt operands
//   d_pred_taken  prediction carried down from F with this branch
//   brjump        branch resolved taken
//   mispredict    resolved direction differs from d_pred_taken
//   stat_branches cycles with a real branch   (BP_STATS_EN only)
//   stat_mispred  cycles with mispredict = 1  (BP_STATS_EN only)
module d_branch_predict_cmp #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned IDX_LSB   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       f_pc,
  output logic              f_pred_taken,
  input  logic              d_valid,
  input  logic [31:0]       d_pc,
  input  logic [2:0]        d_b_type,
  input  logic [DATA_W-1:0] d_in1,
  input  logic [DATA_W-1:0] d_in2,
  input  logic              d_pred_taken,
  output logic              brjump,
  output logic              mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispred
`endif
);

  localparam int unsigned IDXW = $clog2(BHT_DEPTH);

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_t;

  logic [1:0]      bht [BHT_DEPTH];
  logic [IDXW-1:0] lidx;
  logic [IDXW-1:0] uidx;
  logic            real_br;
  logic            result;
  logic            neg;
  logic            zero;

  // The PC bits outside the index window are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc, d_pc};

  assign lidx = f_pc[IDX_LSB +: IDXW];
  assign uidx = d_pc[IDX_LSB +: IDXW];

  // Every counter is 01 while reset is low, so this gating only makes the
  // reset value explicit.
  assign f_pred_taken = reset & bht[lidx][1];

  assign neg  = d_in1[DATA_W-1];
  assign zero = (d_in1 == '0);

  always_comb begin
    real_br = 1'b0;
    result  = 1'b0;
    case (br_t'(d_b_type))
      BR_BEQ:  begin real_br = d_valid; result = (d_in1 == d_in2); end
      BR_BNE:  begin real_br = d_valid; result = (d_in1 != d_in2); end
      BR_BLEZ: begin real_br = d_valid; result = neg | zero;       end
      BR_BGTZ: begin real_br = d_valid; result = ~neg & ~zero;     end
      BR_BLTZ: begin real_br = d_valid; result = neg;              end
      BR_BGEZ: begin real_br = d_valid; result = ~neg;             end
      default: begin real_br = 1'b0;    result = 1'b0;             end
    endcase
  end

  assign brjump     = real_br & result;
  assign mispredict = real_br & (brjump != d_pred_taken);

  // No write-to-read bypass: the lookup sees the pre-update value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (real_br) begin
      if (brjump) begin
        if (bht[uidx] != 2'b11) bht[uidx] <= bht[uidx] + 2'b01;
      end else begin
        if (bht[uidx] != 2'b00) bht[uidx] <= bht[uidx] - 2'b01;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (real_br && (stat_branches != '1)) stat_branches <= stat_branches + 32'd1;
      if (mispredict && (stat_mispred != '1)) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_d_branch_predict_cmp.sv
module tb_d_branch_predict_cmp;

  logic        clk;
  logic        reset;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [2:0]  d_b_type;
  logic [31:0] d_in1;
  logic [31:0] d_in2;
  logic        d_pred_taken;
  logic        brjump;
  logic        mispredict;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
`endif

  int checks;
  int failures;

  d_branch_predict_cmp #(
    .DATA_W   (32),
    .BHT_DEPTH(64),
    .IDX_LSB  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .f_pc         (f_pc),
    .f_pred_taken (f_pred_taken),
    .d_valid      (d_valid),
    .d_pc         (d_pc),
    .d_b_type     (d_b_type),
    .d_in1        (d_in1),
    .d_in2        (d_in2),
    .d_pred_taken (d_pred_taken),
    .brjump       (brjump),
    .mispredict   (mispredict)
`ifdef BP_STATS_EN
    ,
    .stat_branches(stat_branches),
    .stat_mispred (stat_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a D-stage branch at the falling edge. It is sampled at the next
  // rising edge.
  task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic p);
    @(negedge clk);
    d_valid      = v;
    d_b_type     = t;
    d_pc         = pc;
    d_in1        = a;
    d_in2        = b;
    d_pred_taken = p;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    f_pc  = 32'h3010;
    d_valid = 1'b0; d_b_type = 3'd0; d_pc = '0; d_in1 = '0; d_in2 = '0; d_pred_taken = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (f_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL reset_pred_during actual=%b expected=0", f_pred_taken);
    end
    reset = 1'b1;
    for (int i = 0; i < 64; i++) begin
      f_pc = 32'h3000 + 32'(i * 4);
      #1;
      checks++;
      if (f_pred_taken !== 1'b0) begin
        failures++;
        $display("FAIL reset_pred_idx pc=%h actual=%b expected=0", f_pc, f_pred_taken);
      end
    end
`ifdef BP_STATS_EN
    checks++;
    if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin
      failures++;
      $display("FAIL reset_stats actual=%0d/%0d expected=0/0", stat_branches, stat_mispred);
    end
`endif
  endtask

  task automatic test_beq_train();
    // First taken beq: counter 01 -> 10, mispredict because pred was 0.
    drive(1'b1, 3'd1, 32'h3010, 32'h5, 32'h5, 1'b0);
    f_pc = 32'h3010;
    #1;
    checks++;
    if (brjump !== 1'b1 || mispredict !== 1'b1) begin
      failures++;
      $display("FAIL beq_first actual=%b%b expected=11", brjump, mispredict);
    end
    checks++;
    if (f_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL no_bypass actual=%b expected=0", f_pred_taken);
    end
`ifdef BP_STATS_EN
    idle();
    #1;
    checks++;
    if (stat_branches !== 32'd1 || stat_mispred !== 32'd1) begin
      failures++;
      $display("FAIL stats_count actual=%0d/%0d expected=1/1", stat_branches, stat_mispred);
    end
`else
    idle();
    #1;
`endif
    checks++;
    if (f_pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL beq_trained actual=%b expected=1", f_pred_taken);
    end
    // Three more taken: 10 -> 11 -> 11 -> 11.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd1, 32'h3010, 32'h5, 32'h5, 1'b1);
      #1;
      checks++;
      if (brjump !== 1'b1 || mispredict !== 1'b0) begin
        failures++;
        $display("FAIL beq_taken_pred i=%0d actual=%b%b expected=10", i, brjump, mispredict);
      end
    end
    // One not-taken: 11 -> 10, still predicts taken.
    drive(1'b1, 3'd1, 32'h3010, 32'h5, 32'h6, 1'b1);
    #1;
    checks++;
    if (brjump !== 1'b0 || mispredict !== 1'b1) begin
      failures++;
      $display("FAIL beq_not_taken actual=%b%b expected=01", brjump, mispredict);
    end
    idle();
    f_pc = 32'h3010;
    #1;
    checks++;
    if (f_pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL sat_hi_then_dec actual=%b expected=1", f_pred_taken);
    end
    // 0x3110 aliases 0x3010 (same index bits [7:2]), and 0x3014 does not.
    f_pc = 32'h3110;
    #1;
    checks++;
    if (f_pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL alias actual=%b expected=1", f_pred_taken);
    end
    f_pc = 32'h3014;
    #1;
    checks++;
    if (f_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL neighbour actual=%b expected=0", f_pred_taken);
    end
    // Three decrements: 10 -> 01 -> 00 -> 00 (a wrap would give 11).
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd2, 32'h3010, 32'h5, 32'h5, 1'b0);
    idle();
    f_pc = 32'h3010;
    #1;
    checks++;
    if (f_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL sat_lo actual=%b expected=0", f_pred_taken);
    end
    // Two increments from 00: 01, then 10.
    drive(1'b1, 3'd2, 32'h3010, 32'h5, 32'h9, 1'b0);
    idle();
    #1;
    checks++;
    if (f_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL sat_lo_inc1 actual=%b expected=0", f_pred_taken);
    end
    drive(1'b1, 3'd2, 32'h3010, 32'h5, 32'h9, 1'b0);
    idle();
    #1;
    checks++;
    if (f_pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL sat_lo_inc2 actual=%b expected=1", f_pred_taken);
    end
  endtask

  task automatic test_single_operand();
    logic [2:0]  typ [12];
    logic [31:0] opd [12];
    logic        exp [12];
    typ = '{3'd5, 3'd3, 3'd6, 3'd4,  3'd3, 3'd6, 3'd4, 3'd5,  3'd4, 3'd6, 3'd3, 3'd5};
    opd = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
            32'h0, 32'h0, 32'h0, 32'h0,
            32'h5, 32'h5, 32'h5, 32'h5};
    exp = '{1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, typ[i], 32'h3020, opd[i], 32'hFFFF_FFFF, 1'b0);
      #1;
      checks++;
      if (brjump !== exp[i] || mispredict !== exp[i]) begin
        failures++;
        $display("FAIL single_op type=%0d in1=%h actual=%b%b expected=%b%b",
                 typ[i], opd[i], brjump, mispredict, exp[i], exp[i]);
      end
    end
    drive(1'b1, 3'd2, 32'h3020, 32'h3, 32'h4, 1'b1);
    #1;
    checks++;
    if (brjump !== 1'b1 || mispredict !== 1'b0) begin
      failures++;
      $display("FAIL bne_taken actual=%b%b expected=10", brjump, mispredict);
    end
  endtask

  task automatic test_not_real();
    drive(1'b1, 3'd7, 32'h3030, 32'h7, 32'h7, 1'b1);
    #1;
    checks++;
    if (brjump !== 1'b0 || mispredict !== 1'b0) begin
      failures++;
      $display("FAIL type7 actual=%b%b expected=00", brjump, mispredict);
    end
    drive(1'b1, 3'd0, 32'h3030, 32'h7, 32'h7, 1'b1);
    #1;
    checks++;
    if (brjump !== 1'b0 || mispredict !== 1'b0) begin
      failures++;
      $display("FAIL type0 actual=%b%b expected=00", brjump, mispredict);
    end
    drive(1'b0, 3'd1, 32'h3030, 32'h7, 32'h7, 1'b1);
    #1;
    checks++;
    if (brjump !== 1'b0 || mispredict !== 1'b0) begin
      failures++;
      $display("FAIL invalid actual=%b%b expected=00", brjump, mispredict);
    end
    idle();
    f_pc = 32'h3030;
    #1;
    checks++;
    if (f_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL not_real_untrained actual=%b expected=0", f_pred_taken);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd1, 32'h3040, 32'h1, 32'h1, 1'b0);
    idle();
    f_pc = 32'h3040;
    #1;
    checks++;
    if (f_pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL mid_trained actual=%b expected=1", f_pred_taken);
    end
    // Assert reset between clock edges. The lookup must drop with no edge.
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (f_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL async_reset actual=%b expected=0", f_pred_taken);
    end
`ifdef BP_STATS_EN
    checks++;
    if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset_stats actual=%0d/%0d expected=0/0", stat_branches, stat_mispred);
    end
`endif
    // A taken branch at an edge that falls while reset is low is dropped.
    drive(1'b1, 3'd1, 32'h3040, 32'h1, 32'h1, 1'b0);
    @(negedge clk);
    d_valid = 1'b0;
    reset   = 1'b1;
    f_pc    = 32'h3040;
    #1;
    checks++;
    if (f_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL update_in_reset actual=%b expected=0", f_pred_taken);
    end
    f_pc = 32'h3010;
    #1;
    checks++;
    if (f_pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL other_entry_reset actual=%b expected=0", f_pred_taken);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_beq_train();
    test_single_operand();
    test_not_real();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/d_branch_predict_cmp.md
Name: d_branch_predict_cmp

Overview:
- Next-generation D-stage branch resolver for the pipelined MIPS core.
- Resolves conditional branches on operands of parameterised width.
- Holds a table of 2-bit saturating counters. The F stage reads a taken/not-taken prediction from it; the table is trained when the branch resolves in D.
- Flags a mispredict so the hazard/PC logic can redirect fetch and flush F.

Parameters:
DATA_W, 32, operand width in bits; signed tests use bit DATA_W-1
BHT_DEPTH, 64, number of counters; must be a power of 2, minimum 2
IDX_LSB, 2, lowest PC bit used for the table index (word-aligned PCs)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous active-low reset (0 = reset)
f_pc  input  32  F-stage PC used for prediction lookup
f_pred_taken  output  1  prediction for f_pc; combinational table read
d_valid  input  1  D stage holds a live, non-stalled branch this cycle
d_pc  input  32  PC of the D-stage branch
d_b_type  input  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved
d_in1  input  DATA_W  forwarded rs value
d_in2  input  DATA_W  forwarded rt value (used by beq/bne only)
d_pred_taken  input  1  prediction piped down with this branch from F
brjump  output  1  branch resolved taken
mispredict  output  1  resolved direction differs from d_pred_taken

Behaviour:
- IDXW = log2(BHT_DEPTH).
- Lookup index: f_pc[IDX_LSB +: IDXW]. Update index: d_pc[IDX_LSB +: IDXW].
- Counter encoding:
  - 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
  - f_pred_taken = counter[1] of the lookup entry.
- Branch is "real" when d_valid=1 and d_b_type is in 1..6.
- Resolution (combinational, same cycle):
  - beq: d_in1 == d_in2.
  - bne: d_in1 != d_in2.
  - Single-operand tests, with neg = d_in1[DATA_W-1] and zero = (d_in1 == 0):
    - blez: neg | zero
    - bgtz: ~neg & ~zero
    - bltz: neg
    - bgez: ~neg
  - brjump = real & result. brjump = 0 when not real, including type 0 and type 7.
  - mispredict = real & (brjump != d_pred_taken). mispredict = 0 when not real.
- Update (at the rising edge of clk, only when real):
  - Taken: counter increments, saturating at 11.
  - Not taken: counter decrements, saturating at 00.
  - No update when d_valid=0, or when d_b_type is 0 or 7.
- Same-index read and write in one cycle: f_pred_taken shows the pre-update value. There is no write-to-read bypass; the new value is visible the following cycle.
- Aliasing: different PCs that map to the same index share one counter. No tags.
- Reset:
  - When reset goes low, every counter goes to 01 asynchronously, including mid-operation.
  - During reset: f_pred_taken = 0. brjump and mispredict follow the combinational rules and are don't-care to the pipeline.
  - An update whose clock edge coincides with reset asserted is dropped.
- Latency: resolution and mispredict are 0 cycles (combinational in D). Training takes effect 1 cycle after the update edge.
- Stalls: the pipeline deasserts d_valid while D is stalled, so a stalled branch trains exactly once.

Optional Feature:
Macro: BP_STATS_EN
- Defined:
  - Adds outputs stat_branches [31:0] and stat_mispred [31:0].
  - stat_branches counts cycles with a real branch; stat_mispred counts cycles with mispredict=1.
  - Both saturate at 32'hFFFF_FFFF and reset asynchronously to 0.
- Not defined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then drive f_pc = 0x3000..0x30FC step 4 -> f_pred_taken = 0 at every index (all counters 01).
- d_valid=1, d_b_type=1, d_pc=0x3010, d_in1 = d_in2 = 0x5, d_pred_taken=0 -> brjump=1, mispredict=1. Next cycle f_pc=0x3010 -> f_pred_taken=1 (counter 10).
- Same beq taken three more times -> counter saturates at 11. Then not taken once (d_in2=0x6) -> counter 10, f_pred_taken still 1.
- DATA_W=32, d_in1=0x8000_0000: bltz -> 1, blez -> 1, bgez -> 0, bgtz -> 0. d_in1=0: blez -> 1, bgez -> 1, bgtz -> 0, bltz -> 0.
- d_b_type=7 or d_valid=0 with a matching operand pair -> brjump=0, mispredict=0, counter unchanged.
- Pulse reset low mid-run after training 0x3010 to 11 -> f_pred_taken for 0x3010 drops to 0 immediately, without waiting for a clock edge. With BP_STATS_EN, both stat counters read 0.
